acs_pmu: RTL and testbench

Add-compare-select path metric unit for the rate-1/2, K=7, 64-state hard-decision Viterbi decoder. Sits directly downstream of the branch metric (BMC) array. Each cycle it consumes the 2-bit `path_0_bmc`/`path_1_bmc` pairs for all states, updates the registered path metrics and emits one survivor decision bit per state to the traceback memory. It also reports the current best state and its metric.

---
 rtl/acs_pmu.sv | 89 ++++++++
 tb/tb_acs_pmu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/acs_pmu.sv
// Add-compare-select path metric unit for a rate-1/2, K=7 hard-decision Viterbi decoder.
// Updates all state metrics once per symbol, emits survivor decisions, then reports the best state.
module acs_pmu #(
  parameter int N_STATES = 64,
  parameter int SW       = 6,
  parameter int PM_W     = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bm_valid,
  input  logic                    frame_start,
  input  logic [4*N_STATES-1:0]   bm_bus,
  output logic                    dec_valid,
  output logic [N_STATES-1:0]     dec_bits,
  output logic                    best_valid,
  output logic [SW-1:0]           best_state,
  output logic [PM_W-1:0]         best_pm
);

  localparam logic [PM_W-1:0] INIT = PM_W'(1) << (PM_W - 2);

  logic [PM_W-1:0]     pm      [N_STATES];
  logic [PM_W-1:0]     acs_pm  [N_STATES];
  logic [PM_W-1:0]     norm_pm [N_STATES];
  logic [N_STATES-1:0] dec;
  logic                all_high;
  logic [PM_W-1:0]     tv      [N_STATES];
  logic [SW-1:0]       ti      [N_STATES];

  // A frame start replaces the registered metrics with the INIT vector as ACS operands.
  for (genvar j = 0; j < N_STATES; j++) begin : g_acs
    localparam int P0 = j / 2;
    localparam int P1 = j / 2 + N_STATES / 2;
    logic [PM_W-1:0] s0, s1, c0, c1;
    assign s0 = frame_start ? ((P0 == 0) ? '0 : INIT) : pm[P0];
    assign s1 = frame_start ? INIT : pm[P1];
    assign c0 = s0 + PM_W'(bm_bus[4*j +: 2]);
    assign c1 = s1 + PM_W'(bm_bus[4*j+2 +: 2]);
    assign dec[j]    = (c1 < c0);
    assign acs_pm[j] = dec[j] ? c1 : c0;
    assign norm_pm[j] = all_high ? (acs_pm[j] - INIT) : acs_pm[j];
  end

  always_comb begin
    all_high = 1'b1;
    for (int i = 0; i < N_STATES; i++) begin
      if (acs_pm[i] < INIT) all_high = 1'b0;
    end
  end

  // Pairwise reduction; the right operand only wins on strict-less, so lower indices win ties.
  always_comb begin
    for (int i = 0; i < N_STATES; i++) begin
      tv[i] = pm[i];
      ti[i] = SW'(i);
    end
    for (int s = 1; s < N_STATES; s = s * 2) begin
      for (int i = 0; i < N_STATES; i = i + 2 * s) begin
        if (tv[i+s] < tv[i]) begin
          tv[i] = tv[i+s];
          ti[i] = ti[i+s];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_STATES; i++) pm[i] <= (i == 0) ? '0 : INIT;
      dec_bits   <= '0;
      dec_valid  <= 1'b0;
      best_valid <= 1'b0;
      best_state <= '0;
      best_pm    <= '0;
    end else begin
      dec_valid  <= bm_valid;
      best_valid <= dec_valid;
      if (bm_valid) begin
        pm       <= norm_pm;
        dec_bits <= dec;
      end
      if (dec_valid) begin
        best_state <= ti[0];
        best_pm    <= tv[0];
      end
    end
  end

endmodule

// File: tb/tb_acs_pmu.sv
// Directed bench for acs_pmu: an integer trellis model is compared on every cycle,
// and hand-computed values pin key points of the model.
module tb_acs_pmu;

  localparam int N  = 64;
  localparam int SW = 6;
  localparam int PW = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            bm_valid = 1'b0;
  logic            frame_start = 1'b0;
  logic [4*N-1:0]  bm_bus = '0;
  logic            dec_valid;
  logic [N-1:0]    dec_bits;
  logic            best_valid;
  logic [SW-1:0]   best_state;
  logic [PW-1:0]   best_pm;

  int vectors = 0;
  int miscompares = 0;

  acs_pmu #(.N_STATES(N), .SW(SW), .PM_W(PW)) dut (
    .clk(clk), .rst(rst), .bm_valid(bm_valid), .frame_start(frame_start),
    .bm_bus(bm_bus), .dec_valid(dec_valid), .dec_bits(dec_bits),
    .best_valid(best_valid), .best_state(best_state), .best_pm(best_pm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain integer metrics, min-select and normalization as arithmetic.
  int         m_pm [N];
  bit         m_dec_valid, m_best_valid;
  bit [N-1:0] m_dec_bits;
  int         m_best_state, m_best_pm;

  function automatic int init_val(input int j);
    return (j == 0) ? 0 : 32;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N; j++) m_pm[j] = init_val(j);
      m_dec_valid = 0; m_best_valid = 0; m_dec_bits = '0;
      m_best_state = 0; m_best_pm = 0;
    end else begin
      int src [N];
      int nw  [N];
      int mn;
      if (m_dec_valid) begin
        mn = 0;
        for (int j = 1; j < N; j++) if (m_pm[j] < m_pm[mn]) mn = j;
        m_best_state = mn;
        m_best_pm    = m_pm[mn];
      end
      m_best_valid = m_dec_valid;
      if (bm_valid) begin
        bit all_high;
        for (int j = 0; j < N; j++) src[j] = frame_start ? init_val(j) : m_pm[j];
        all_high = 1;
        for (int j = 0; j < N; j++) begin
          int c0, c1;
          c0 = src[j/2] + int'(bm_bus[4*j +: 2]);
          c1 = src[j/2 + N/2] + int'(bm_bus[4*j+2 +: 2]);
          m_dec_bits[j] = (c1 < c0);
          nw[j] = (c1 < c0) ? c1 : c0;
          if (nw[j] < 32) all_high = 0;
        end
        for (int j = 0; j < N; j++) m_pm[j] = all_high ? nw[j] - 32 : nw[j];
      end
      m_dec_valid = bm_valid;
    end
  end

  always @(negedge clk) begin
    check("dec_valid",  64'(dec_valid),  64'(m_dec_valid));
    check("dec_bits",   64'(dec_bits),   64'(m_dec_bits));
    check("best_valid", 64'(best_valid), 64'(m_best_valid));
    check("best_state", 64'(best_state), 64'(m_best_state));
    check("best_pm",    64'(best_pm),    64'(m_best_pm));
  end

  task automatic drive(input bit v, input bit fs, input logic [4*N-1:0] bus);
    @(negedge clk); #1;
    bm_valid = v; frame_start = fs; bm_bus = bus;
  endtask

  logic [4*N-1:0] all2, pat_a, pat_b, one5;

  initial begin
    all2  = {N{4'b1010}};
    pat_a = {(N/4){16'h1B3E}};
    pat_b = {(N/8){32'hC4F0_2A97}};
    one5  = '0;
    one5[21:20] = 2'd2;

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) drive(0, 0, '0);
    check("idle_dec_valid",  64'(dec_valid),  64'd0);
    check("idle_best_valid", 64'(best_valid), 64'd0);
    check("idle_dec_bits",   64'(dec_bits),   64'd0);
    check("idle_best_pm",    64'(best_pm),    64'd0);

    // All-zero branch metrics from INIT
    drive(1, 1, '0);
    drive(0, 0, '0);
    check("zero_dec_valid", 64'(dec_valid), 64'd1);
    check("zero_dec_bits",  64'(dec_bits),  64'd0);
    drive(0, 0, '0);
    check("zero_best_valid", 64'(best_valid), 64'd1);
    check("zero_best_state", 64'(best_state), 64'd0);
    check("zero_best_pm",    64'(best_pm),    64'd0);
    check("zero_dec_drop",   64'(dec_valid),  64'd0);

    // State 5 prefers p1: 32+2 vs 32+0
    drive(1, 1, one5);
    drive(0, 0, '0);
    check("s5_dec_bits", 64'(dec_bits), 64'h20);

    // Normalization: 16 symbols of bm=2; best of symbol k is 2k until 16 wraps to 0
    for (int i = 1; i <= 16; i++) begin
      drive(1, i == 1, all2);
      if (i >= 3) begin
        check("norm_best_valid", 64'(best_valid), 64'd1);
        check("norm_best_pm",    64'(best_pm),    64'(2 * (i - 2)));
      end
    end
    drive(0, 0, '0);
    check("norm_best_pm15", 64'(best_pm), 64'd30);
    drive(0, 0, '0);
    check("norm_best_pm16", 64'(best_pm), 64'd0);
    check("norm_best_valid16", 64'(best_valid), 64'd1);

    // Mixed patterns with gaps; outputs hold while idle
    drive(1, 1, pat_a);
    drive(1, 0, pat_b);
    drive(0, 0, '0);
    drive(0, 0, '0);
    drive(0, 0, '0);
    check("gap_dec_valid",  64'(dec_valid),  64'd0);
    check("gap_best_valid", 64'(best_valid), 64'd0);
    drive(1, 0, pat_a);
    drive(1, 0, all2);
    drive(0, 0, '0);
    drive(1, 0, pat_b);
    drive(1, 1, pat_b);
    drive(1, 1, pat_a);
    drive(1, 0, '0);
    drive(0, 0, '0);
    drive(0, 0, '0);

    // Reset one cycle after a valid symbol discards its best pulse
    drive(1, 0, pat_a);
    @(negedge clk); #1;
    bm_valid = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_best_valid", 64'(best_valid), 64'd0);
    end
    #1 rst = 1'b0;
    drive(0, 0, '0);
    check("rst_best_valid2", 64'(best_valid), 64'd0);
    // Non-frame-start zero symbol from INIT behaves like a fresh frame
    drive(1, 0, '0);
    drive(0, 0, '0);
    check("rst_dec_bits", 64'(dec_bits), 64'd0);
    drive(0, 0, '0);
    check("rst_best_valid3", 64'(best_valid), 64'd1);
    check("rst_best_pm",     64'(best_pm),    64'd0);
    drive(0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
